// File: rtl/sw_watch_mode_cu_pkg.sv
// Shared definitions for the watch/stopwatch mode controller: state encodings,
// field codes, ASCII command bytes and small decode helpers.
package sw_watch_mode_cu_pkg;

  typedef enum logic [2:0] {
    ST_SW      = 3'd0,
    ST_W_RUN   = 3'd1,
    ST_W_SET_H = 3'd2,
    ST_W_SET_M = 3'd3,
    ST_W_SET_S = 3'd4
  } state_e;

  localparam logic [1:0] FLD_NONE = 2'b00;
  localparam logic [1:0] FLD_HOUR = 2'b01;
  localparam logic [1:0] FLD_MIN  = 2'b10;
  localparam logic [1:0] FLD_SEC  = 2'b11;

  // Upper-case command bytes; lower-case input is folded before compare.
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] CMD_S = 8'h53;
  localparam logic [7:0] CMD_C = 8'h43;
  localparam logic [7:0] CMD_M = 8'h4D;
  localparam logic [7:0] CMD_T = 8'h54;
  localparam logic [7:0] CMD_N = 8'h4E;
  localparam logic [7:0] CMD_U = 8'h55;
  localparam logic [7:0] CMD_D = 8'h44;
  localparam logic [7:0] CMD_E = 8'h45;

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    return b;
  endfunction

  function automatic logic is_set(input state_e s);
    return (s == ST_W_SET_H) || (s == ST_W_SET_M) || (s == ST_W_SET_S);
  endfunction

  function automatic logic [1:0] field_of(input state_e s);
    case (s)
      ST_W_SET_H: return FLD_HOUR;
      ST_W_SET_M: return FLD_MIN;
      ST_W_SET_S: return FLD_SEC;
      default:    return FLD_NONE;
    endcase
  endfunction

  // Field sequence H -> M -> S -> back to running watch.
  function automatic state_e next_field(input state_e s);
    case (s)
      ST_W_SET_H: return ST_W_SET_M;
      ST_W_SET_M: return ST_W_SET_S;
      default:    return ST_W_RUN;
    endcase
  endfunction

endpackage

// File: rtl/sw_watch_mode_cu_if.sv
// Button/UART inputs and stopwatch/watch control outputs of the mode controller.
// slave = the controller, master = whatever drives the buttons and UART.
interface sw_watch_mode_cu_if;
  logic       i_btn_mode;
  logic       i_btn_a;
  logic       i_btn_b;
  logic       i_btn_c;
  logic [7:0] uart_rx;
  logic       uart_rx_done;
  logic       o_sel_watch;
  logic       o_sw_runstop;
  logic       o_sw_clear;
  logic [7:0] o_sw_rx;
  logic       o_sw_rx_done;
  logic       o_w_set;
  logic [1:0] o_w_field;
  logic       o_w_inc;
  logic       o_w_dec;
  logic       o_blink;

  modport master (
    output i_btn_mode, i_btn_a, i_btn_b, i_btn_c, uart_rx, uart_rx_done,
    input  o_sel_watch, o_sw_runstop, o_sw_clear, o_sw_rx, o_sw_rx_done,
           o_w_set, o_w_field, o_w_inc, o_w_dec, o_blink
  );

  modport slave (
    input  i_btn_mode, i_btn_a, i_btn_b, i_btn_c, uart_rx, uart_rx_done,
    output o_sel_watch, o_sw_runstop, o_sw_clear, o_sw_rx, o_sw_rx_done,
           o_w_set, o_w_field, o_w_inc, o_w_dec, o_blink
  );
endinterface

// File: rtl/sw_watch_mode_cu_set_timer.sv
// Inactivity timeout and digit-blink timers for the watch set states.
// Both are down-counters that reload on their clear and fire at zero.
module sw_watch_mode_cu_set_timer #(
  parameter int TIMEOUT_CYC = 500_000_000,
  parameter int BLINK_CYC   = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic fld_clr,
  output logic timeout,
  output logic blink
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] BL_LOAD = BW'(BLINK_CYC - 1);

  logic [TW-1:0] to_cnt;
  logic [BW-1:0] bl_cnt;

  assign timeout = en && (to_cnt == '0);

  // Timeout count: reload on entry/accepted event, then count down and hold at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      to_cnt <= '0;
    else if (clr)                 to_cnt <= TO_LOAD;
    else if (en && to_cnt != '0)  to_cnt <= to_cnt - TW'(1);
  end

  // Blink half-period count: restart lit on field change, toggle at terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bl_cnt <= '0;
      blink  <= 1'b1;
    end else if (fld_clr) begin
      bl_cnt <= BL_LOAD;
      blink  <= 1'b1;
    end else if (en) begin
      if (bl_cnt == '0) begin
        bl_cnt <= BL_LOAD;
        blink  <= ~blink;
      end else begin
        bl_cnt <= bl_cnt - BW'(1);
      end
    end
  end

endmodule

// File: rtl/sw_watch_mode_cu.sv
// Mode controller: shares buttons and UART commands between the stopwatch
// control unit and the watch time-set sequence.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_SW      | stopwatch selected; buttons/bytes go to stopwatch control
//  ST_W_RUN   | watch displayed and running
//  ST_W_SET_H | setting hours (watch counters held)
//  ST_W_SET_M | setting minutes
//  ST_W_SET_S | setting seconds
module sw_watch_mode_cu
  import sw_watch_mode_cu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 500_000_000,
  parameter int BLINK_CYC   = 25_000_000
) (
  input logic              clk,
  input logic              rst,
  sw_watch_mode_cu_if.slave bus
);

  state_e     state_q, state_d;
  logic       runstop_d, clear_d, inc_d, dec_d, rx_done_d, accept;
  logic       timeout, blink, tmr_clr, fld_clr, rx_ev;
  logic [7:0] cmd;

  assign rx_ev = bus.uart_rx_done;
  assign cmd   = to_upper(bus.uart_rx);

  // Next state and pulse decode; events handled highest priority first, the rest dropped.
  always_comb begin
    state_d   = state_q;
    runstop_d = 1'b0;
    clear_d   = 1'b0;
    inc_d     = 1'b0;
    dec_d     = 1'b0;
    rx_done_d = 1'b0;
    accept    = 1'b0;
    case (state_q)
      ST_SW: begin
        if (bus.i_btn_mode)                  state_d = ST_W_RUN;
        else if (bus.i_btn_a)                runstop_d = 1'b1;
        else if (bus.i_btn_b)                clear_d = 1'b1;
        else if (rx_ev && cmd == CMD_M)      state_d = ST_W_RUN;
        else if (rx_ev)                      rx_done_d = 1'b1;
      end
      ST_W_RUN: begin
        if (bus.i_btn_mode)                  state_d = ST_SW;
        else if (bus.i_btn_a)                state_d = ST_W_SET_H;
        else if (rx_ev && cmd == CMD_M)      state_d = ST_SW;
        else if (rx_ev && cmd == CMD_T)      state_d = ST_W_SET_H;
      end
      ST_W_SET_H, ST_W_SET_M, ST_W_SET_S: begin
        accept = 1'b1;
        if (bus.i_btn_mode)                  state_d = ST_SW;
        else if (bus.i_btn_a)                state_d = next_field(state_q);
        else if (bus.i_btn_b)                inc_d = 1'b1;
        else if (bus.i_btn_c)                dec_d = 1'b1;
        else if (rx_ev && cmd == CMD_M)      state_d = ST_SW;
        else if (rx_ev && cmd == CMD_N)      state_d = next_field(state_q);
        else if (rx_ev && cmd == CMD_U)      inc_d = 1'b1;
        else if (rx_ev && cmd == CMD_D)      dec_d = 1'b1;
        else if (rx_ev && cmd == CMD_E)      state_d = ST_W_RUN;
        else begin
          accept = 1'b0;
          if (timeout) state_d = ST_W_RUN;
        end
      end
      default: state_d = ST_SW;
    endcase
  end

  // Timers restart whenever the set sequence is not (or no longer) idle.
  assign tmr_clr = !is_set(state_d) || accept;
  assign fld_clr = !is_set(state_d) || (state_d != state_q);

  sw_watch_mode_cu_set_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .BLINK_CYC   (BLINK_CYC)
  ) u_set_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (is_set(state_q)),
    .clr     (tmr_clr),
    .fld_clr (fld_clr),
    .timeout (timeout),
    .blink   (blink)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_SW;
    else     state_q <= state_d;
  end

  // Output registers, decoded from the next state so they track state_q exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.o_sel_watch  <= 1'b0;
      bus.o_sw_runstop <= 1'b0;
      bus.o_sw_clear   <= 1'b0;
      bus.o_sw_rx      <= 8'h00;
      bus.o_sw_rx_done <= 1'b0;
      bus.o_w_set      <= 1'b0;
      bus.o_w_field    <= FLD_NONE;
      bus.o_w_inc      <= 1'b0;
      bus.o_w_dec      <= 1'b0;
    end else begin
      bus.o_sel_watch  <= (state_d != ST_SW);
      bus.o_sw_runstop <= runstop_d;
      bus.o_sw_clear   <= clear_d;
      bus.o_sw_rx      <= bus.uart_rx;
      bus.o_sw_rx_done <= rx_done_d;
      bus.o_w_set      <= is_set(state_d);
      bus.o_w_field    <= field_of(state_d);
      bus.o_w_inc      <= inc_d;
      bus.o_w_dec      <= dec_d;
    end
  end

  assign bus.o_blink = blink;

endmodule

// File: tb/tb_sw_watch_mode_cu.sv
// Directed bench for the watch/stopwatch mode controller (short timers).
module tb_sw_watch_mode_cu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  sw_watch_mode_cu_if bus();

  sw_watch_mode_cu #(
    .TIMEOUT_CYC (20),
    .BLINK_CYC   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.i_btn_mode   = 1'b0;
    bus.i_btn_a      = 1'b0;
    bus.i_btn_b      = 1'b0;
    bus.i_btn_c      = 1'b0;
    bus.uart_rx      = 8'h00;
    bus.uart_rx_done = 1'b0;
  endtask

  // One-cycle stimulus; on return the registered response is visible.
  task automatic drv(input logic m, input logic a, input logic b, input logic c,
                     input logic rd, input logic [7:0] rx);
    bus.i_btn_mode   = m;
    bus.i_btn_a      = a;
    bus.i_btn_b      = b;
    bus.i_btn_c      = c;
    bus.uart_rx      = rx;
    bus.uart_rx_done = rd;
    cyc();
    clr_in();
  endtask

  initial begin
    clr_in();
    repeat (3) cyc();
    chk("rst_sel", bus.o_sel_watch, 0);
    chk("rst_blink", bus.o_blink, 1);
    chk("rst_field", bus.o_w_field, 0);
    chk("rst_set", bus.o_w_set, 0);
    chk("rst_runstop", bus.o_sw_runstop, 0);
    rst = 1'b0;
    cyc();

    // Stopwatch routing
    drv(0, 1, 0, 0, 0, 8'h00);
    chk("sw_runstop", bus.o_sw_runstop, 1);
    chk("sw_sel", bus.o_sel_watch, 0);
    cyc();
    chk("sw_runstop_1cyc", bus.o_sw_runstop, 0);
    drv(0, 0, 1, 0, 0, 8'h00);
    chk("sw_clear", bus.o_sw_clear, 1);
    drv(0, 1, 1, 0, 0, 8'h00);
    chk("sw_prio_runstop", bus.o_sw_runstop, 1);
    chk("sw_prio_clear", bus.o_sw_clear, 0);
    drv(0, 0, 0, 0, 1, 8'h47);
    chk("sw_fwd_done", bus.o_sw_rx_done, 1);
    chk("sw_fwd_byte", bus.o_sw_rx, 8'h47);
    cyc();
    chk("sw_fwd_done_1cyc", bus.o_sw_rx_done, 0);

    // 'M' toggles to watch, not forwarded
    drv(0, 0, 0, 0, 1, 8'h4D);
    chk("m_sel", bus.o_sel_watch, 1);
    chk("m_not_fwd", bus.o_sw_rx_done, 0);
    drv(0, 0, 0, 0, 1, 8'h47);
    chk("wrun_g_done", bus.o_sw_rx_done, 0);
    chk("wrun_g_set", bus.o_w_set, 0);
    chk("wrun_g_sel", bus.o_sel_watch, 1);
    drv(0, 0, 1, 0, 0, 8'h00);
    chk("wrun_b_inc", bus.o_w_inc, 0);
    chk("wrun_b_clear", bus.o_sw_clear, 0);

    // Field stepping with btn_a, inc/dec in W_SET_M
    drv(0, 1, 0, 0, 0, 8'h00);
    chk("set_h_field", bus.o_w_field, 2'b01);
    chk("set_h_set", bus.o_w_set, 1);
    chk("set_h_blink", bus.o_blink, 1);
    drv(0, 1, 0, 0, 0, 8'h00);
    chk("set_m_field", bus.o_w_field, 2'b10);
    drv(0, 0, 0, 0, 1, 8'h75);
    chk("u_inc", bus.o_w_inc, 1);
    chk("u_dec", bus.o_w_dec, 0);
    cyc();
    chk("u_inc_1cyc", bus.o_w_inc, 0);
    drv(0, 0, 1, 1, 0, 8'h00);
    chk("bc_inc", bus.o_w_inc, 1);
    chk("bc_dec", bus.o_w_dec, 0);
    drv(0, 0, 0, 1, 0, 8'h00);
    chk("c_dec", bus.o_w_dec, 1);
    chk("c_inc", bus.o_w_inc, 0);
    drv(0, 0, 0, 0, 1, 8'h64);
    chk("d_dec", bus.o_w_dec, 1);
    drv(0, 1, 0, 0, 0, 8'h00);
    chk("set_s_field", bus.o_w_field, 2'b11);
    drv(0, 1, 0, 0, 0, 8'h00);
    chk("exit4_field", bus.o_w_field, 2'b00);
    chk("exit4_set", bus.o_w_set, 0);
    chk("exit4_sel", bus.o_sel_watch, 1);

    // Idle timeout with blink
    drv(0, 0, 0, 0, 1, 8'h74);
    chk("t_field", bus.o_w_field, 2'b01);
    chk("t_blink", bus.o_blink, 1);
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k < 20) begin
        chk($sformatf("idle_set_%0d", k), bus.o_w_set, 1);
        chk($sformatf("idle_blink_%0d", k), bus.o_blink, ((k / 4) % 2 == 0) ? 1 : 0);
      end else begin
        chk("to_set", bus.o_w_set, 0);
        chk("to_field", bus.o_w_field, 0);
        chk("to_blink", bus.o_blink, 1);
        chk("to_sel", bus.o_sel_watch, 1);
      end
    end

    // Accepted event restarts the timeout
    drv(0, 0, 0, 0, 1, 8'h54);
    repeat (10) cyc();
    drv(0, 0, 0, 0, 1, 8'h55);
    chk("restart_inc", bus.o_w_inc, 1);
    repeat (19) cyc();
    chk("restart_still_set", bus.o_w_set, 1);
    cyc();
    chk("restart_to", bus.o_w_set, 0);

    // Field change restarts blink lit
    drv(0, 1, 0, 0, 0, 8'h00);
    repeat (5) cyc();
    chk("blink_off", bus.o_blink, 0);
    drv(0, 0, 0, 0, 1, 8'h6E);
    chk("n_field", bus.o_w_field, 2'b10);
    chk("n_blink", bus.o_blink, 1);
    drv(0, 0, 0, 0, 1, 8'h4E);
    chk("n2_field", bus.o_w_field, 2'b11);

    // btn_mode beats 'E' in W_SET_S
    drv(1, 0, 0, 0, 1, 8'h45);
    chk("me_sel", bus.o_sel_watch, 0);
    chk("me_set", bus.o_w_set, 0);
    chk("me_field", bus.o_w_field, 0);
    chk("me_done", bus.o_sw_rx_done, 0);
    cyc();
    chk("me_sel_hold", bus.o_sel_watch, 0);
    chk("me_done_hold", bus.o_sw_rx_done, 0);

    // 'e' exits set to W_RUN
    drv(0, 0, 0, 0, 1, 8'h6D);
    drv(0, 1, 0, 0, 0, 8'h00);
    chk("e_pre_set", bus.o_w_set, 1);
    drv(0, 0, 0, 0, 1, 8'h65);
    chk("e_set", bus.o_w_set, 0);
    chk("e_sel", bus.o_sel_watch, 1);

    // Async reset mid-set with a pulse live
    drv(0, 1, 0, 0, 0, 8'h00);
    drv(0, 0, 1, 0, 0, 8'h00);
    chk("pre_rst_inc", bus.o_w_inc, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_inc", bus.o_w_inc, 0);
    chk("rst_mid_set", bus.o_w_set, 0);
    chk("rst_mid_sel", bus.o_sel_watch, 0);
    chk("rst_mid_field", bus.o_w_field, 0);
    chk("rst_mid_blink", bus.o_blink, 1);
    cyc();
    rst = 1'b0;
    cyc();
    drv(0, 1, 0, 0, 0, 8'h00);
    chk("post_rst_runstop", bus.o_sw_runstop, 1);
    chk("post_rst_sel", bus.o_sel_watch, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
